wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Writeback-side consumer of the MEM/WB pipeline register. Decodes the WB
//  control pair, selects the writeback value (ALU result or load data) and
//  commits it to a 2-read/1-write architectural register file. Read ports
//  feed the ID stage. Also drives the writeback value for EX forwarding and
//  counts retired (non-bubble) instructions.
// PARAMETERS
//  DATA_W   32  register and datapath width
//  ADDR_W   5   register address width (2**ADDR_W registers)
//  CNT_W    32  retired-instruction counter width
//  BYPASS   1   1 = same-cycle write-to-read bypass; 0 = reads see old value
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  WB         in   2       from MEM/WB: [1]=RegWrite, [0]=MemtoReg
//  Dest_reg   in   ADDR_W  from MEM/WB: destination register
//  Alu_out    in   DATA_W  from MEM/WB: ALU result
//  Mem_data   in   DATA_W  load data from data memory, aligned to MEM/WB
//  Inst       in   32      from MEM/WB: instruction word (0 = bubble)
//  Rs_addr    in   ADDR_W  read port A address (ID stage)
//  Rt_addr    in   ADDR_W  read port B address (ID stage)
//  Rs_data    out  DATA_W  read port A data
//  Rt_data    out  DATA_W  read port B data
//  Wb_data    out  DATA_W  selected writeback value (to forwarding mux)
//  Wb_en      out  1       effective write enable (to forwarding unit)
//  Retired    out  CNT_W   count of retired non-bubble instructions
// BEHAVIOUR
//  - Wb_data = WB[0] ? Mem_data : Alu_out; combinational, no latency.
//  - Wb_en = WB[1] && (Dest_reg != 0); combinational.
//  - Write: at rising clock edge, if !reset && Wb_en, reg[Dest_reg] <= Wb_data.
//  - Register 0 is never written; always reads 0.
//  - Reads are combinational (asynchronous) from the array.
//  - BYPASS=1: if Wb_en && Rx_addr == Dest_reg, Rx_data = Wb_data in the same
//    cycle (both ports independently). BYPASS=0: Rx_data shows the old value
//    until the edge.
//  - Both read ports may address the same register; both return identical data.
//  - Retired: increments by 1 at each edge where !reset && Inst != 0,
//    independent of WB. Wraps from 2**CNT_W-1 to 0 with no flag.
//  - Reset (synchronous, active-high): at the edge with reset=1, all 2**ADDR_W
//    registers <= 0 and Retired <= 0. Reset has priority over a simultaneous
//    write and a simultaneous retire. After a reset edge, Rs_data and Rt_data
//    read 0, unless a bypass from the live WB inputs applies.
//  - Asserting reset mid-stream discards the in-flight write of that cycle.
//    The first write after reset deasserts lands at the next edge.
//  - No X propagation: outputs are defined whenever the inputs are defined.
// STRUCTURE
//  - Shared package (pipe_pkg): WB_REGWRITE=1, WB_MEMTOREG=0 bit indices;
//    NOP_INST=32'h0; DATA_W/ADDR_W defaults. Also used by the MEM/WB register
//    and the forwarding unit.
//  - One sub-module: regfile_2r1w (storage array, reg0 hardwiring, bypass,
//    reset clear). The top level holds the WB mux, Wb_en decode and the retire
//    counter.
// TESTING
//  1. Reset 2 cycles -> Rs_data=Rt_data=0 for addrs 0..31, Retired=0.
//  2. WB=2'b10, Dest_reg=5, Alu_out=32'hDEAD_BEEF, 1 edge; then read Rs_addr=5
//     -> 32'hDEADBEEF. Same with WB=2'b11, Mem_data=32'h1234 to reg 6 -> 0x1234.
//  3. WB=2'b10, Dest_reg=0, Alu_out=32'hFFFF_FFFF -> Wb_en=0; reg0 still reads 0.
//  4. BYPASS=1: Dest_reg=7, Alu_out=32'hA5A5, WB=2'b10, Rs_addr=Rt_addr=7 in the
//     same cycle -> both read 32'hA5A5 before the edge. BYPASS=0 -> old value.
//  5. WB=2'b00 with Dest_reg=9 -> reg 9 unchanged. Inst=0 for 3 edges then
//     nonzero for 4 -> Retired=4.
//  6. Reset asserted on the same edge as write of 32'h55 to reg 3 -> reg 3=0,
//     Retired=0. CNT_W=4: 16 retires from 0 -> Retired=0 (wrap).

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants for MEM/WB, writeback and forwarding
package pipe_pkg;
    localparam int WB_REGWRITE    = 1;
    localparam int WB_MEMTOREG    = 0;
    localparam logic [31:0] NOP_INST = 32'h0;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 5;
endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register array with hardwired reg0 and optional write bypass
module regfile_2r1w
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [NREGS];
    logic              w_we;

    assign w_we = i_we && (i_waddr != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reg0 is forced to zero on read so it never depends on array contents.
    always_comb begin
        o_rdata_a = '0;
        if (i_raddr_a != '0) begin
            if (BYPASS != 0 && w_we && i_raddr_a == i_waddr) o_rdata_a = i_wdata;
            else                                             o_rdata_a = r_mem[i_raddr_a];
        end
    end

    always_comb begin
        o_rdata_b = '0;
        if (i_raddr_b != '0) begin
            if (BYPASS != 0 && w_we && i_raddr_b == i_waddr) o_rdata_b = i_wdata;
            else                                             o_rdata_b = r_mem[i_raddr_b];
        end
    end
endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage: WB value select, write enable decode, register file, retire counter
module wb_regfile
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = 32,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        WB,
    input  logic [ADDR_W-1:0] Dest_reg,
    input  logic [DATA_W-1:0] Alu_out,
    input  logic [DATA_W-1:0] Mem_data,
    input  logic [31:0]       Inst,
    input  logic [ADDR_W-1:0] Rs_addr,
    input  logic [ADDR_W-1:0] Rt_addr,
    output logic [DATA_W-1:0] Rs_data,
    output logic [DATA_W-1:0] Rt_data,
    output logic [DATA_W-1:0] Wb_data,
    output logic              Wb_en,
    output logic [CNT_W-1:0]  Retired
);
    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_en;
    logic [CNT_W-1:0]  r_retired;

    assign w_wb_data = WB[WB_MEMTOREG] ? Mem_data : Alu_out;
    assign w_wb_en   = WB[WB_REGWRITE] && (Dest_reg != '0);

    // Bubbles (all-zero instruction words) do not count as retired.
    always_ff @(posedge clock) begin
        if (reset)                 r_retired <= '0;
        else if (Inst != NOP_INST) r_retired <= r_retired + 1'b1;
    end

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rf (
        .clock     (clock),
        .reset     (reset),
        .i_we      (w_wb_en),
        .i_waddr   (Dest_reg),
        .i_wdata   (w_wb_data),
        .i_raddr_a (Rs_addr),
        .i_raddr_b (Rt_addr),
        .o_rdata_a (Rs_data),
        .o_rdata_b (Rt_data)
    );

    assign Wb_data = w_wb_data;
    assign Wb_en   = w_wb_en;
    assign Retired = r_retired;
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed bench for wb_regfile (bypass, no-bypass and 4-bit counter builds)
module tb_wb_regfile;
    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  WB;
    logic [4:0]  Dest_reg, Rs_addr, Rt_addr;
    logic [31:0] Alu_out, Mem_data, Inst;

    logic [31:0] rs0, rt0, wbd0, ret0;
    logic [31:0] rs1, rt1, wbd1, ret1;
    logic [31:0] rs2, rt2, wbd2;
    logic [3:0]  ret2;
    logic        wen0, wen1, wen2;

    int tests = 0;
    int failed = 0;

    always #5 clock = ~clock;

    wb_regfile #(.BYPASS(1)) dut_byp (
        .clock(clock), .reset(reset), .WB(WB), .Dest_reg(Dest_reg), .Alu_out(Alu_out),
        .Mem_data(Mem_data), .Inst(Inst), .Rs_addr(Rs_addr), .Rt_addr(Rt_addr),
        .Rs_data(rs0), .Rt_data(rt0), .Wb_data(wbd0), .Wb_en(wen0), .Retired(ret0));

    wb_regfile #(.BYPASS(0)) dut_nobyp (
        .clock(clock), .reset(reset), .WB(WB), .Dest_reg(Dest_reg), .Alu_out(Alu_out),
        .Mem_data(Mem_data), .Inst(Inst), .Rs_addr(Rs_addr), .Rt_addr(Rt_addr),
        .Rs_data(rs1), .Rt_data(rt1), .Wb_data(wbd1), .Wb_en(wen1), .Retired(ret1));

    wb_regfile #(.CNT_W(4)) dut_cnt4 (
        .clock(clock), .reset(reset), .WB(WB), .Dest_reg(Dest_reg), .Alu_out(Alu_out),
        .Mem_data(Mem_data), .Inst(Inst), .Rs_addr(Rs_addr), .Rt_addr(Rt_addr),
        .Rs_data(rs2), .Rt_data(rt2), .Wb_data(wbd2), .Wb_en(wen2), .Retired(ret2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; WB = 2'b00; Dest_reg = 5'd0; Alu_out = 32'h0; Mem_data = 32'h0;
        Inst = 32'h0; Rs_addr = 5'd0; Rt_addr = 5'd0;

        // 1. reset state
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset_retired", ret0, 32'd0);
        check("reset_retired_cnt4", {28'd0, ret2}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            Rs_addr = 5'(i); Rt_addr = 5'(31 - i);
            #1;
            check($sformatf("reset_rs_%0d", i), rs0, 32'd0);
            check($sformatf("reset_rt_%0d", 31 - i), rt1, 32'd0);
        end

        // 2. ALU and load writebacks
        WB = 2'b10; Dest_reg = 5'd5; Alu_out = 32'hDEAD_BEEF; Mem_data = 32'h0BAD_F00D;
        #1;
        check("alu_wb_data", wbd0, 32'hDEAD_BEEF);
        check("alu_wb_en", {31'd0, wen0}, 32'd1);
        tick();
        WB = 2'b00; Rs_addr = 5'd5;
        #1;
        check("reg5_rs", rs0, 32'hDEAD_BEEF);
        check("reg5_rs_nobyp", rs1, 32'hDEAD_BEEF);
        WB = 2'b11; Dest_reg = 5'd6; Mem_data = 32'h0000_1234; Alu_out = 32'h7777_7777;
        #1;
        check("load_wb_data", wbd0, 32'h0000_1234);
        tick();
        WB = 2'b00; Rt_addr = 5'd6;
        #1;
        check("reg6_rt", rt0, 32'h0000_1234);
        check("reg6_rt_nobyp", rt1, 32'h0000_1234);

        // 3. writes to reg0 are dropped
        WB = 2'b10; Dest_reg = 5'd0; Alu_out = 32'hFFFF_FFFF; Rs_addr = 5'd0;
        #1;
        check("reg0_wb_en", {31'd0, wen0}, 32'd0);
        check("reg0_wb_data", wbd0, 32'hFFFF_FFFF);
        check("reg0_bypass", rs0, 32'd0);
        tick();
        WB = 2'b00;
        #1;
        check("reg0_after", rs0, 32'd0);
        check("reg0_after_nobyp", rs1, 32'd0);

        // 4. same-cycle bypass on both ports vs. old value
        WB = 2'b10; Dest_reg = 5'd7; Alu_out = 32'h0000_A5A5; Rs_addr = 5'd7; Rt_addr = 5'd7;
        #1;
        check("byp_rs", rs0, 32'h0000_A5A5);
        check("byp_rt", rt0, 32'h0000_A5A5);
        check("nobyp_rs_old", rs1, 32'd0);
        check("nobyp_rt_old", rt1, 32'd0);
        tick();
        WB = 2'b00;
        #1;
        check("nobyp_rs_new", rs1, 32'h0000_A5A5);
        check("nobyp_rt_new", rt1, 32'h0000_A5A5);

        // 5. RegWrite low leaves reg 9 alone; bubbles are not retired
        WB = 2'b00; Dest_reg = 5'd9; Alu_out = 32'h1111_1111; Rs_addr = 5'd9;
        #1;
        check("no_regwrite_en", {31'd0, wen0}, 32'd0);
        check("no_regwrite_byp", rs0, 32'd0);
        tick();
        check("reg9_unchanged", rs0, 32'd0);
        Inst = 32'h0;
        tick(); tick(); tick();
        Inst = 32'h0000_0013;
        tick(); tick(); tick(); tick();
        Inst = 32'h0;
        check("retired_4", ret0, 32'd4);
        check("retired_4_nobyp", ret1, 32'd4);
        check("retired_4_cnt4", {28'd0, ret2}, 32'd4);

        // 6. reset beats a simultaneous write and retire
        reset = 1'b1; WB = 2'b10; Dest_reg = 5'd3; Alu_out = 32'h55; Inst = 32'h1;
        tick();
        reset = 1'b0; WB = 2'b00; Inst = 32'h0; Rs_addr = 5'd3; Rt_addr = 5'd5;
        #1;
        check("reset_drops_write", rs0, 32'd0);
        check("reset_clears_reg5", rt0, 32'd0);
        check("reset_retired_prio", ret0, 32'd0);
        WB = 2'b10; Dest_reg = 5'd3; Alu_out = 32'h77;
        tick();
        WB = 2'b00;
        #1;
        check("first_write_after_reset", rs1, 32'h77);

        // CNT_W=4 wraps after 16 retires
        Inst = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) tick();
        check("wrap_cnt4", {28'd0, ret2}, 32'd0);
        check("no_wrap_cnt32", ret0, 32'd16);
        tick();
        Inst = 32'h0;
        check("after_wrap_cnt4", {28'd0, ret2}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
